// File: rtl/fp_wb_buffer_pkg.sv
// Shared core types used by the FP writeback buffer and other flushable stages.
package fp_wb_buffer_pkg;

    localparam int SQN_W = 7;
    localparam int TAG_W = 7;
    localparam int NM_W  = 5;
    localparam int RES_W = 32;

    typedef logic [SQN_W-1:0] SqN;
    typedef logic [TAG_W-1:0] Tag;
    typedef logic [NM_W-1:0]  RegNm;

    typedef enum logic [3:0] {
        FLAGS_NONE   = 4'd0,
        FLAGS_BRK    = 4'd1,
        FLAGS_TRAP   = 4'd2,
        FLAGS_EXCEPT = 4'd3,
        FLAGS_FP_NX  = 4'd4,
        FLAGS_FP_UF  = 4'd5,
        FLAGS_FP_OF  = 4'd6,
        FLAGS_FP_DZ  = 4'd7,
        FLAGS_FP_NV  = 4'd8
    } Flags;

    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;

    typedef struct packed {
        logic [RES_W-1:0] result;
        Tag               tagDst;
        RegNm             nmDst;
        SqN               sqN;
        Flags             flags;
        logic             doNotCommit;
        logic             valid;
    } RES_UOp;

    // True when a is strictly younger than b in the wrapping sequence space,
    // i.e. $signed(a - b) > 0: non-zero difference with a clear sign bit.
    function automatic logic is_younger(input SqN a, input SqN b);
        SqN w_diff;
        w_diff = a - b;
        return (w_diff != '0) && !w_diff[SQN_W-1];
    endfunction

endpackage

// File: rtl/fp_wb_buffer_fifo_mem.sv
// Storage array for the FP writeback buffer: DEPTH result entries plus a
// valid bit per entry. Valid bits are cleared by the flush-kill vector and by
// retiring the head slot; a write always leaves its slot valid.
module fp_wb_fifo_mem
    import fp_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_wr_en,
    input  logic [PTR_W-1:0]            i_wr_ptr,
    input  RES_UOp                      i_wr_data,
    input  logic                        i_rd_en,
    input  logic [PTR_W-1:0]            i_rd_ptr,
    input  logic [DEPTH-1:0]            i_kill,
    output RES_UOp                      o_rd_data,
    output logic [DEPTH-1:0]            o_valid,
    output logic [DEPTH-1:0][SQN_W-1:0] o_sqn
);

    RES_UOp             r_data [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   w_valid_next;

    // Valid-bit update: kill, then retire head, then mark the written slot.
    always_comb begin
        w_valid_next = r_valid & ~i_kill;
        if (i_rd_en) begin
            w_valid_next[i_rd_ptr] = 1'b0;
        end
        if (i_wr_en) begin
            w_valid_next[i_wr_ptr] = 1'b1;
        end
    end

    // Valid bits are the only storage state that needs a reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_next;
        end
    end

    // Payload storage; contents of invalid slots are never observed.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_data[i_rd_ptr];
    assign o_valid   = r_valid;

    for (genvar g = 0; g < DEPTH; g++) begin : g_sqn
        assign o_sqn[g] = r_data[g].sqN;
    end

endmodule

// File: rtl/fp_wb_buffer.sv
// In-order result buffer between the FP multiplier and the shared writeback
// port. Empty buffer with a free output register bypasses straight to the
// output; otherwise results queue and drain in arrival order. Flushed slots
// keep their place in the ring and are retired one per cycle as bubbles.
module fp_wb_buffer
    import fp_wb_buffer_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STALL_MARGIN = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  BranchProv IN_branch,
    input  RES_UOp    IN_uop,
    input  logic      IN_wbStall,
    output RES_UOp    OUT_uop,
    output logic      OUT_stall,
    output logic      OUT_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - STALL_MARGIN);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    RES_UOp           r_out;
    logic             r_stall;
    logic             r_overflow;

    RES_UOp                      w_mem_rd;
    logic [DEPTH-1:0]            w_mem_valid;
    logic [DEPTH-1:0][SQN_W-1:0] w_mem_sqn;
    logic [DEPTH-1:0]            w_kill;

    logic             w_in_live;
    logic             w_out_kill;
    logic             w_out_free;
    logic             w_head_valid;
    logic             w_deq;
    logic             w_bypass;
    logic             w_enq_req;
    logic             w_enq;
    logic             w_overflow;
    logic [CNT_W-1:0] w_count_next;
    RES_UOp           w_out_next;

    // Flush kill vector for the stored entries.
    always_comb begin
        w_kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_kill[i] = IN_branch.taken && w_mem_valid[i]
                        && is_younger(SqN'(w_mem_sqn[i]), IN_branch.sqN);
        end
    end

    // Dequeue / bypass / enqueue decision and next output register value.
    always_comb begin
        w_in_live    = IN_uop.valid
                       && !(IN_branch.taken && is_younger(IN_uop.sqN, IN_branch.sqN));
        w_out_kill   = r_out.valid && IN_branch.taken
                       && is_younger(r_out.sqN, IN_branch.sqN);
        w_out_free   = !r_out.valid || !IN_wbStall || w_out_kill;
        w_head_valid = w_mem_valid[r_rd_ptr] && !w_kill[r_rd_ptr];

        w_out_next = r_out;
        if (w_out_kill) begin
            w_out_next.valid = 1'b0;
        end
        w_deq    = 1'b0;
        w_bypass = 1'b0;

        if (w_out_free) begin
            if (r_count != '0) begin
                w_deq = 1'b1;
                if (w_head_valid) begin
                    w_out_next       = w_mem_rd;
                    w_out_next.valid = 1'b1;
                end else begin
                    w_out_next.valid = 1'b0;
                end
            end else if (w_in_live) begin
                w_bypass   = 1'b1;
                w_out_next = IN_uop;
            end else begin
                w_out_next.valid = 1'b0;
            end
        end

        w_enq_req    = w_in_live && !w_bypass;
        w_enq        = w_enq_req && ((r_count != FULL_CNT) || w_deq);
        w_overflow   = w_enq_req && (r_count == FULL_CNT) && !w_deq;
        w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end

    fp_wb_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_enq),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (IN_uop),
        .i_rd_en   (w_deq),
        .i_rd_ptr  (r_rd_ptr),
        .i_kill    (w_kill),
        .o_rd_data (w_mem_rd),
        .o_valid   (w_mem_valid),
        .o_sqn     (w_mem_sqn)
    );

    // Pointers, occupancy, output register, early stall and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_out      <= '0;
            r_stall    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_out   <= w_out_next;
            r_stall <= (w_count_next >= STALL_CNT);
            if (w_overflow) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Overflow means FP issue ignored OUT_stall; make it visible in simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!w_overflow)
                else $warning("fp_wb_buffer: uop sqN %0d dropped, buffer full", IN_uop.sqN);
        end
    end

    assign OUT_uop      = r_out;
    assign OUT_stall    = r_stall;
    assign OUT_overflow = r_overflow;

endmodule

// File: tb/tb_fp_wb_buffer.sv
// Directed bench for fp_wb_buffer (DEPTH=4, STALL_MARGIN=2).
module tb_fp_wb_buffer;
    import fp_wb_buffer_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b0;
    logic      IN_wbStall = 1'b0;
    BranchProv IN_branch;
    RES_UOp    IN_uop;
    RES_UOp    OUT_uop;
    logic      OUT_stall;
    logic      OUT_overflow;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_wb_buffer #(
        .DEPTH        (4),
        .STALL_MARGIN (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_branch    (IN_branch),
        .IN_uop       (IN_uop),
        .IN_wbStall   (IN_wbStall),
        .OUT_uop      (OUT_uop),
        .OUT_stall    (OUT_stall),
        .OUT_overflow (OUT_overflow)
    );

    function automatic RES_UOp mk(input logic [6:0] s, input logic [31:0] r);
        RES_UOp u;
        u             = '0;
        u.valid       = 1'b1;
        u.sqN         = s;
        u.result      = r;
        u.tagDst      = s + 7'd10;
        u.nmDst       = s[4:0];
        u.flags       = FLAGS_NONE;
        return u;
    endfunction

    // Expected-state word: {valid, sqN (0 when invalid), stall, count}.
    function automatic logic [11:0] e(input logic v, input logic [6:0] s,
                                      input logic st, input logic [2:0] c);
        return {v, v ? s : 7'd0, st, c};
    endfunction

    function automatic logic [11:0] snap();
        return {OUT_uop.valid, OUT_uop.valid ? OUT_uop.sqN : 7'd0, OUT_stall, dut.r_count};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus (sqN 0 with v=0 means idle) and advance.
    task automatic drive(input logic v, input logic [6:0] s, input logic stl,
                         input logic bt, input logic [6:0] bs);
        IN_uop           = v ? mk(s, {25'd0, s}) : '0;
        IN_wbStall       = stl;
        IN_branch.taken  = bt;
        IN_branch.sqN    = bs;
        step();
    endtask

    task automatic do_reset();
        IN_uop     = '0;
        IN_branch  = '0;
        IN_wbStall = 1'b0;
        rst        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        do_reset();
        n_vec++;
        got = snap();
        if (got !== e(0, 0, 0, 0) || OUT_overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset got %h ovf %b want %h ovf 0", got, OUT_overflow, e(0, 0, 0, 0));
        end
    endtask

    task automatic test_bypass();
        RES_UOp u;
        logic [11:0] got;
        do_reset();
        u             = mk(7'd5, 32'h3F800000);
        u.flags       = FLAGS_FP_NX;
        u.doNotCommit = 1'b1;
        IN_uop        = u;
        step();
        IN_uop = '0;
        n_vec++;
        if (OUT_uop !== u) begin
            n_bad++;
            $display("FAIL bypass_fields got %h want %h", OUT_uop, u);
        end
        n_vec++;
        got = snap();
        if (got !== e(1, 5, 0, 0)) begin
            n_bad++;
            $display("FAIL bypass_state got %h want %h", got, e(1, 5, 0, 0));
        end
        step();
        n_vec++;
        got = snap();
        if (got !== e(0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL bypass_drain got %h want %h", got, e(0, 0, 0, 0));
        end
    endtask

    task automatic test_stall_fill();
        logic        v_t   [9];
        logic [6:0]  s_t   [9];
        logic        st_t  [9];
        logic [11:0] exp_t [9];
        logic [11:0] got;
        v_t   = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        s_t   = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        st_t  = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
        exp_t = '{e(1, 1, 0, 0), e(1, 1, 0, 1), e(1, 1, 1, 2), e(1, 1, 1, 3), e(1, 1, 1, 3),
                  e(1, 2, 1, 2), e(1, 3, 0, 1), e(1, 4, 0, 0), e(0, 0, 0, 0)};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(v_t[k], s_t[k], st_t[k], 1'b0, 7'd0);
            n_vec++;
            got = snap();
            if (got !== exp_t[k]) begin
                n_bad++;
                $display("FAIL stall_fill step %0d got %h want %h", k, got, exp_t[k]);
            end
        end
    endtask

    task automatic test_flush();
        logic        v_t   [9];
        logic [6:0]  s_t   [9];
        logic        st_t  [9];
        logic        bt_t  [9];
        logic [11:0] exp_t [9];
        logic [11:0] got;
        v_t   = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        s_t   = '{2, 3, 6, 9, 0, 0, 0, 0, 0};
        st_t  = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
        bt_t  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        exp_t = '{e(1, 2, 0, 0), e(1, 2, 0, 1), e(1, 2, 1, 2), e(1, 2, 1, 3), e(1, 2, 1, 3),
                  e(1, 3, 1, 2), e(0, 0, 0, 1), e(0, 0, 0, 0), e(0, 0, 0, 0)};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(v_t[k], s_t[k], st_t[k], bt_t[k], 7'd4);
            n_vec++;
            got = snap();
            if (got !== exp_t[k]) begin
                n_bad++;
                $display("FAIL flush step %0d got %h want %h", k, got, exp_t[k]);
            end
        end
    endtask

    task automatic test_equal_sqn();
        logic        v_t   [5];
        logic [6:0]  s_t   [5];
        logic        st_t  [5];
        logic [6:0]  bs_t  [5];
        logic [11:0] exp_t [5];
        logic [11:0] got;
        // equal sqN survives, younger dies, wrap-around younger dies,
        // wrap-around older survives, stalled output killed by a flush
        v_t   = '{1, 1, 1, 1, 0};
        s_t   = '{7, 8, 2, 125, 0};
        st_t  = '{0, 0, 0, 1, 1};
        bs_t  = '{7, 7, 126, 126, 100};
        exp_t = '{e(1, 7, 0, 0), e(0, 0, 0, 0), e(0, 0, 0, 0), e(1, 125, 0, 0), e(0, 0, 0, 0)};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(v_t[k], s_t[k], st_t[k], 1'b1, bs_t[k]);
            n_vec++;
            got = snap();
            if (got !== exp_t[k]) begin
                n_bad++;
                $display("FAIL equal_sqn step %0d got %h want %h", k, got, exp_t[k]);
            end
        end
    endtask

    task automatic test_overflow();
        logic        v_t   [12];
        logic [6:0]  s_t   [12];
        logic        st_t  [12];
        logic        ov_t  [12];
        logic [11:0] exp_t [12];
        logic [11:0] got;
        v_t   = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        s_t   = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0};
        st_t  = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        ov_t  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        exp_t = '{e(1, 1, 0, 0), e(1, 1, 0, 1), e(1, 1, 1, 2), e(1, 1, 1, 3),
                  e(1, 1, 1, 4), e(1, 1, 1, 4), e(1, 1, 1, 4), e(1, 2, 1, 3),
                  e(1, 3, 1, 2), e(1, 4, 0, 1), e(1, 5, 0, 0), e(0, 0, 0, 0)};
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(v_t[k], s_t[k], st_t[k], 1'b0, 7'd0);
            n_vec++;
            got = snap();
            if (got !== exp_t[k] || OUT_overflow !== ov_t[k]) begin
                n_bad++;
                $display("FAIL overflow step %0d got %h ovf %b want %h ovf %b",
                         k, got, OUT_overflow, exp_t[k], ov_t[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] got;
        do_reset();
        drive(1, 1, 1, 0, 0);
        drive(1, 2, 1, 0, 0);
        drive(1, 3, 1, 0, 0);
        drive(1, 4, 1, 0, 0);
        drive(1, 5, 0, 0, 0);
        IN_uop = '0;
        n_vec++;
        got = snap();
        if (got !== e(1, 2, 1, 3)) begin
            n_bad++;
            $display("FAIL async_reset_pre got %h want %h", got, e(1, 2, 1, 3));
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        got = snap();
        if (got !== e(0, 0, 0, 0) || OUT_overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_now got %h ovf %b want %h ovf 0", got, OUT_overflow, e(0, 0, 0, 0));
        end
        #1;
        rst = 1'b1;
        step();
        n_vec++;
        got = snap();
        if (got !== e(0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL async_reset_after got %h want %h", got, e(0, 0, 0, 0));
        end
    endtask

    initial begin
        IN_uop    = '0;
        IN_branch = '0;
        test_reset();
        test_bypass();
        test_stall_fill();
        test_flush();
        test_equal_sqn();
        test_overflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_wb_buffer.md
Name: fp_wb_buffer

Overview:
- Downstream neighbour of the FP multiply stage.
- Accepts the single-cycle RES_UOp produced by the FP multiplier and buffers it in a small in-order FIFO.
- Presents results to the shared integer/FP writeback port, which can refuse a cycle (IN_wbStall).
- Discards entries younger than a taken branch.
- Raises OUT_stall early so FP issue stops before the buffer can overflow.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >= 2).
- STALL_MARGIN, 2, free slots still left when OUT_stall asserts; covers the issue-to-result pipeline depth.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; clk and rst are the block's only clock and reset.
- IN_branch  in  BranchProv  taken flag and sqN of the resolving branch.
- IN_uop  in  RES_UOp  result from the FP multiplier; valid, tagDst, nmDst, sqN, result, flags, doNotCommit.
- IN_wbStall  in  1  writeback port did not accept OUT_uop this cycle.
- OUT_uop  out  RES_UOp  registered result towards writeback.
- OUT_stall  out  1  tells FP issue to stop issuing multiplies.
- OUT_overflow  out  1  sticky error: a valid uop arrived while the buffer was full.

Behaviour:
- Storage:
  - Circular buffer of DEPTH RES_UOp entries with per-entry valid bits.
  - Pointers rdPtr and wrPtr are clog2(DEPTH) bits wide and wrap modulo DEPTH.
  - count is clog2(DEPTH+1) bits and counts occupied slots, including slots invalidated by a flush.
- Reset (rst low, asynchronous): count=0, pointers=0, all entry valid bits=0, OUT_uop.valid=0, OUT_stall=0, OUT_overflow=0. The remaining OUT_uop fields are don't-care.
- Flush test: an entry, incoming uop or output register is killed when IN_branch.taken and $signed(x.sqN - IN_branch.sqN) > 0. A uop with sqN equal to the branch sqN survives.
- Output register: OUT_uop is "free" when !OUT_uop.valid, or OUT_uop.valid && !IN_wbStall, or OUT_uop is killed by a flush this cycle.
- Per-cycle priority:
  1. Flush: clear the valid bit of every killed entry. Clear OUT_uop.valid if OUT_uop is killed. Drop IN_uop if it is killed. Pointers and count are not rewound.
  2. Dequeue (output free):
     - If count>0 and the head entry is valid: load the head into OUT_uop and advance rdPtr.
     - If count>0 and the head entry is invalid: advance rdPtr and set OUT_uop.valid=0. At most one slot is retired per cycle.
     - If count==0 and IN_uop is valid and surviving: bypass IN_uop directly into OUT_uop; it is not written to the FIFO.
     - Otherwise set OUT_uop.valid=0.
  3. Enqueue: a surviving valid IN_uop that was not bypassed is written at wrPtr and wrPtr advances. This is legal in the same cycle as a dequeue when count==DEPTH.
  4. count updates as count + enq - deq; deq counts retired invalid slots as well.
- Latency: 1 cycle from IN_uop to OUT_uop when the buffer is empty and the output is free. Otherwise results leave in arrival order.
- Held output: while OUT_uop.valid && IN_wbStall, OUT_uop holds all fields stable, unless a flush kills it.
- OUT_stall: registered, = (next count >= DEPTH - STALL_MARGIN).
- Overflow:
  - Condition: a valid surviving IN_uop arrives with count==DEPTH and no dequeue that cycle.
  - The uop is dropped. OUT_overflow sets and stays set until reset.
  - A simulation assertion fires.
- Field pass-through: all RES_UOp fields, including flags, are passed unmodified; the block never alters flags.

Decomposition:
- RES_UOp, BranchProv and Flags come from the shared core types package.
- Add one package helper there: function is_younger(sqN a, sqN b) returning $signed(a-b) > 0. It is reused by every flushable stage.
- One sub-module is natural: fp_wb_fifo_mem, the DEPTH-entry storage array with valid bits and a flush-kill vector input.
- Control, bypass and the output register stay in the top module.

Test Plan:
- Empty, no stall: IN_uop valid, sqN=5, result=0x3F800000 -> next cycle OUT_uop.valid=1, sqN=5, result=0x3F800000; count stays 0.
- IN_wbStall held high while 4 uops arrive (sqN 1..4) -> sqN 1 is held in OUT_uop, sqN 2..4 are buffered, OUT_stall=1 once count>=2; after the stall drops, sqN 2, 3, 4 emerge on consecutive cycles.
- Buffer holds sqN 3,6,9 with OUT_uop=sqN 2 stalled; taken branch sqN=4 -> OUT_uop stays sqN 2; after the stall drops only sqN 3 is emitted; the invalid slots are retired at one per cycle with OUT_uop.valid=0; count returns to 0.
- Flush with equal sqN: branch sqN=7, incoming IN_uop sqN=7 -> the uop survives and is output next cycle.
- Full with stall held (DEPTH=4 plus held output) and a 6th valid uop arrives -> OUT_overflow=1 and the uop is dropped; the buffered contents are unchanged.
- Reset pulse (rst low) asserted asynchronously mid-drain with count=3 -> OUT_uop.valid=0, OUT_stall=0 and count=0 immediately, without waiting for a clock edge.
